// File: rtl/stream_sorter.sv
// Batch insertion sorter: accepts N unsigned W-bit elements, keeps them sorted on arrival,
// then streams them out. Define STREAM_SORTER_ASCEND_EN to emit min-first instead of max-first.
module stream_sorter #(
    parameter int unsigned W  = 4,
    parameter int unsigned N  = 4,
    localparam int unsigned CW = $clog2(N + 1),
    localparam int unsigned IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [N*W-1:0] out_word,
    output logic [CW-1:0]  count
);

    typedef enum logic [0:0] {
        S_LOAD  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_buf [N];
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_idx;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;

    logic [CW-1:0] w_pos;
    logic [W-1:0]  w_ins [N];

    // Map drain index to buffer slot; buffer is always held descending.
    function automatic logic [IW-1:0] f_sel(input logic [CW-1:0] idx);
`ifdef STREAM_SORTER_ASCEND_EN
        return IW'(N - 1) - IW'(idx);
`else
        return IW'(idx);
`endif
    endfunction

    // Insert position is past every held element >= in_data, so equal values keep arrival order.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            if ((CW'(i) < r_count) && (r_buf[i] >= in_data)) begin
                w_pos = w_pos + CW'(1);
            end
        end
        w_ins[0] = (w_pos == '0) ? in_data : r_buf[0];
        for (int i = 1; i < N; i++) begin
            w_ins[i] = r_buf[i];
            if (CW'(i) == w_pos) begin
                w_ins[i] = in_data;
            end else if ((CW'(i) > w_pos) && (CW'(i) <= r_count)) begin
                w_ins[i] = r_buf[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_count     <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else if (flush) begin
            r_state     <= S_LOAD;
            r_count     <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= r_buf[f_sel('0)];
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            r_buf[i] <= w_ins[i];
                        end
                        r_out_data <= w_ins[f_sel('0)];
                        r_idx      <= '0;
                        if (r_count == CW'(N - 1)) begin
                            r_state     <= S_DRAIN;
                            r_count     <= CW'(N);
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_count == CW'(1)) begin
                            r_state     <= S_LOAD;
                            r_count     <= '0;
                            r_idx       <= '0;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_data  <= r_buf[f_sel('0)];
                        end else begin
                            r_idx      <= r_idx + CW'(1);
                            r_count    <= r_count - CW'(1);
                            r_out_data <= r_buf[f_sel(r_idx + CW'(1))];
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // Packed view: slot 0 (largest) lands in the top nibble.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_word[(N-i)*W-1 -: W] = r_buf[i];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;

endmodule
